change_dispenser: RTL

- Downstream stage of the vending machine FSM. Consumes its change (pdt/cng) and cancel-refund (rtn) outputs.
- Drives the coin-ejector solenoid one coin at a time and confirms each coin on the drop sensor.
- Tracks coin-tube stock; flags timeout and empty faults to the front panel.

---
 rtl/vm_pkg.sv | 24 ++
 rtl/dispense_timer.sv | 34 +++
 rtl/change_dispenser.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: definitions shared by the vending machine FSM and the change dispenser.
//   - disp_state_t : change dispenser state encoding
//   - FLT_*        : fault codes reported to the front panel
//   - COIN_W       : width of a coin count (change / refund amounts)
package vm_pkg;

    localparam int COIN_W = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        EJECT     = 3'd2,
        WAIT_DROP = 3'd3,
        DONE      = 3'd4,
        FAULT     = 3'd5
    } disp_state_t;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FLT_NONE    = 2'b00;
    localparam fault_code_t FLT_TIMEOUT = 2'b01;
    localparam fault_code_t FLT_EMPTY   = 2'b10;

endpackage

// File: rtl/dispense_timer.sv
// dispense_timer: loadable up-counter with a terminal-count flag.
//   clk, rst : clock, synchronous active-high reset
//   load     : restart the count at zero (takes priority over en)
//   en       : advance the count by one
//   limit    : terminal value; tc is high while count == limit
//   tc       : terminal-count flag
// The dispenser reuses one instance for both the eject pulse and the
// drop timeout by switching 'limit' with the state.
module dispense_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change / cancel refunds one coin at a time.
//   clk, rst     : clock, synchronous active-high reset
//   pdt, cng     : product released + change amount from the vending FSM
//   rtn          : cancel-refund amount from the vending FSM
//   coin_drop    : synchronised drop sensor, high while a coin passes
//   refill       : one-cycle strobe, adds refill_cnt coins to the tube
//   fault_clr    : one-cycle fault acknowledge
//   eject        : solenoid drive
//   busy         : job in progress (not IDLE, not FAULT)
//   done         : one-cycle pulse at job completion
//   fault        : high in FAULT; fault_code gives the reason
//   paid_out     : coins dispensed by the current or last job
//   stock        : coins left in the tube
//   overrun      : sticky, a request edge arrived while busy or faulted
module change_dispenser
    import vm_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int STOCK_W     = 6,
    parameter int STOCK_INIT  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pdt,
    input  logic [COIN_W-1:0]  cng,
    input  logic [COIN_W-1:0]  rtn,
    input  logic               coin_drop,
    input  logic               refill,
    input  logic [STOCK_W-1:0] refill_cnt,
    input  logic               fault_clr,
    output logic               eject,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [COIN_W-1:0]  paid_out,
    output logic [STOCK_W-1:0] stock,
    output logic               overrun
);

    localparam int MAX_CYC = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0]      PULSE_LIM = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0]      TO_LIM    = TW'(TIMEOUT_CYC - 1);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    disp_state_t         state, state_n;
    logic [COIN_W-1:0]   req_amt;
    logic [COIN_W-1:0]   remaining;
    logic                req_nz, req_nz_d, start;
    logic                coin_drop_d, drop_rise;
    logic [STOCK_W:0]    stock_sum;
    logic [STOCK_W-1:0]  stock_sat;
    logic                refill_ok;
    logic                tmr_load, tmr_en, tmr_tc;
    logic [TW-1:0]       tmr_limit;

    // Change wins over refund when both are present.
    assign req_amt = (pdt && cng != '0) ? cng : rtn;
    assign req_nz  = (req_amt != '0);
    // Edge-triggered so a request level held by the vending FSM runs once.
    assign start   = req_nz & ~req_nz_d;

    assign drop_rise = coin_drop & ~coin_drop_d;

    // Refill saturates at the top of the counter range.
    assign stock_sum = {1'b0, stock} + {1'b0, refill_cnt};
    assign stock_sat = stock_sum[STOCK_W] ? {STOCK_W{1'b1}} : stock_sum[STOCK_W-1:0];
    assign refill_ok = refill && (state == IDLE || state == FAULT);

    // One timer serves both intervals: restart on entry to EJECT (from CHECK)
    // and on entry to WAIT_DROP (EJECT terminal count).
    assign tmr_load  = (state == CHECK) || (state == EJECT && tmr_tc);
    assign tmr_en    = (state == EJECT) || (state == WAIT_DROP);
    assign tmr_limit = (state == EJECT) ? PULSE_LIM : TO_LIM;

    dispense_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (start) state_n = CHECK;
            CHECK:     state_n = (stock == '0) ? FAULT : EJECT;
            EJECT:     if (tmr_tc) state_n = WAIT_DROP;
            WAIT_DROP: begin
                // A drop on the last timeout cycle still counts as a coin.
                if (drop_rise) begin
                    state_n = (remaining == COIN_W'(1)) ? DONE : CHECK;
                end else if (tmr_tc) begin
                    state_n = FAULT;
                end
            end
            DONE:      state_n = IDLE;
            FAULT:     if (fault_clr) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        eject = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        fault = 1'b0;
        case (state)
            CHECK:     busy = 1'b1;
            // Gate with rst so the solenoid releases in the cycle reset is seen.
            EJECT:     begin busy = 1'b1; eject = ~rst; end
            WAIT_DROP: busy = 1'b1;
            DONE:      begin busy = 1'b1; done = 1'b1; end
            FAULT:     fault = 1'b1;
            default:   ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_nz_d    <= 1'b0;
            coin_drop_d <= 1'b0;
            remaining   <= '0;
            paid_out    <= '0;
            stock       <= STOCK_RST;
            fault_code  <= FLT_NONE;
            overrun     <= 1'b0;
        end else begin
            req_nz_d    <= req_nz;
            coin_drop_d <= coin_drop;

            if (start) begin
                if (state == IDLE) begin
                    remaining <= req_amt;
                    paid_out  <= '0;
                end else begin
                    overrun <= 1'b1;
                end
            end

            if (refill_ok) begin
                stock <= stock_sat;
            end

            if (state == CHECK && stock == '0) begin
                fault_code <= FLT_EMPTY;
            end

            if (state == WAIT_DROP) begin
                if (drop_rise) begin
                    remaining <= remaining - 1'b1;
                    stock     <= stock - 1'b1;
                    paid_out  <= paid_out + 1'b1;
                end else if (tmr_tc) begin
                    fault_code <= FLT_TIMEOUT;
                end
            end

            if (state == FAULT) begin
                remaining <= '0;
                if (fault_clr) begin
                    fault_code <= FLT_NONE;
                end
            end
        end
    end

endmodule
